bus_trace_fifo: RTL and testbench
=================================

# bus_trace_fifo

Bus-cycle trace capture for the 6502C core. Sits directly downstream of `top_6502C` on the external bus (extAB, extDB, RW, SYNC, RDY), alongside the memory model. It arms on a trigger (opcode fetch at a chosen address, or any fetch), records one entry per completed bus cycle into a FIFO, and lets the bench or a debug port drain entries, replacing per-cycle `$display` dumps with a checkable record.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 4
- CNT_W, $clog2(DEPTH)+1, width of `count`
- phi2  in  1  clock; same `phi2_out` that clocks memory; all capture on rising edge
- RES_L  in  1  asynchronous, active-low reset
- extAB  in  16  CPU address bus
- extDB  in  8  CPU data bus, resolved value for the cycle
- RW  in  1  1 = read, 0 = write
- SYNC  in  1  opcode-fetch cycle marker
- RDY  in  1  0 = CPU stalled; cycle not recorded
- arm  in  1  single-cycle pulse: start waiting for trigger
- trig_any  in  1  1 = trigger on any SYNC cycle; 0 = SYNC with extAB == trig_addr
- trig_addr  in  16  trigger address
- stop  in  1  end capture, return to IDLE
- clear  in  1  flush FIFO, clear `overflow` and `stamp`
- rd_en  in  1  pop head entry; ignored when empty
- rd_data  out  42  head entry {stamp[15:0], AB[15:0], DB[7:0], RW, SYNC}; first-word-fall-through
- empty  out  1  FIFO empty
- full  out  1  FIFO holds DEPTH entries
- count  out  CNT_W  entries held, 0..DEPTH
- overflow  out  1  sticky: a capture-eligible cycle was dropped because FIFO was full
- state_o  out  2  current FSM state, for debug

## Operation
- FSM states: IDLE (00), ARMED (01), CAPTURE (10). 11 unused; decodes to IDLE.
- IDLE: `arm` → ARMED. No capture.
- ARMED: at an edge with RDY=1, SYNC=1 and (trig_any or extAB==trig_addr), that cycle is written as the first entry and the state moves to CAPTURE.
- CAPTURE: every edge with RDY=1 writes one entry. RDY=0 edges write nothing, and `stamp` still advances.
- `stop` in ARMED or CAPTURE → IDLE. The cycle on the `stop` edge is not captured.
- Priority at a single edge: clear > stop > arm > trigger/capture. `arm` while in CAPTURE is ignored.
- `stamp`: free-running 16-bit counter. 0 after reset or `clear`, +1 every edge, wraps 0xFFFF→0x0000. An entry holds the stamp value before that edge's increment.
- Full: writes are dropped, `overflow` sets, and the state stays CAPTURE. A read and a write on the same edge when full are both accepted and `count` stays at DEPTH.
- Empty: `rd_en` is a no-op, and pointers and `count` do not change. When empty, `rd_data` holds its last value.
- `clear` resets pointers, `count`, `overflow` and `stamp`, and leaves the FSM state unchanged.
- Pointers are CNT_W-1 bits and wrap modulo DEPTH.

## Timing
- Reset (async assert): state IDLE, `count`=0, `empty`=1, `full`=0, `overflow`=0, `stamp`=0, `rd_data`=0. Deassertion takes effect at the next phi2 edge.
- Write latency: an entry captured at edge N appears on `rd_data`/`count` after edge N, and `empty` falls after N.
- Read: `rd_data` is valid whenever `empty`=0. A `rd_en` pop at edge N presents the next entry after N.
- Reset mid-capture discards all contents. No partial entry is ever visible.

## Structure
- Shared package `trace_pkg.vh`: state encodings (`TR_IDLE`, `TR_ARMED`, `TR_CAPT`) and entry field offsets (`TR_SYNC`=0, `TR_RW`=1, `TR_DB`=9:2, `TR_AB`=25:10, `TR_STAMP`=41:26).
- One sub-module: `trace_fifo_mem`, a DEPTH×42 register array with synchronous write and asynchronous read. FSM, stamp, pointers and flags live in `bus_trace_fifo`.

## Test plan
- Reset, arm, trig_any=0, trig_addr=0xF000, drive a SYNC fetch at 0xF000 with DB=0xA9 RW=1 → first entry {stamp, F000, A9, 1, 1}, state 10, count=1.
- Armed, SYNC at 0xF002 with trig_addr=0xF000 → no capture, state stays 01. Then SYNC at 0xF000 → capture starts.
- CAPTURE for 20 cycles with no reads, DEPTH=16 → count=16, full=1, overflow=1. The 16 entries have consecutive stamps, and the first dropped cycle is entry 17.
- Full, with rd_en and a capture on the same edge → count stays 16, the new tail entry is stored, and the head advances by one.
- RDY=0 for 3 cycles mid-capture → no entries for those cycles, and the next entry's stamp jumps by 4.
- Assert `clear` and `stop` together during CAPTURE, then RES_L low mid-stream → after clear: count=0, overflow=0, state IDLE. After reset: all outputs at reset values.

Source files
------------

// File: rtl/bus_trace_fifo_pkg.sv
// Shared definitions for the 6502C bus-cycle trace capture: FSM encodings and
// the bit layout of one trace entry.
package bus_trace_fifo_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'b00,
        TR_ARMED = 2'b01,
        TR_CAPT  = 2'b10
    } tr_state_e;

    localparam int ENTRY_W      = 42;
    localparam int TR_SYNC      = 0;
    localparam int TR_RW        = 1;
    localparam int TR_DB_LSB    = 2;
    localparam int TR_AB_LSB    = 10;
    localparam int TR_STAMP_LSB = 26;

    function automatic logic [ENTRY_W-1:0] tr_pack(
        input logic [15:0] stamp,
        input logic [15:0] ab,
        input logic [7:0]  db,
        input logic        rw,
        input logic        sync
    );
        logic [ENTRY_W-1:0] e;
        e                       = '0;
        e[TR_STAMP_LSB +: 16]   = stamp;
        e[TR_AB_LSB +: 16]      = ab;
        e[TR_DB_LSB +: 8]       = db;
        e[TR_RW]                = rw;
        e[TR_SYNC]              = sync;
        return e;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: DEPTH x ENTRY_W register array, synchronous write,
// asynchronous read.
module trace_fifo_mem
    import bus_trace_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_trace_fifo.sv
// Bus-cycle trace capture for the 6502C external bus: arms on an opcode-fetch
// trigger, then records one entry per completed (RDY=1) cycle into a FWFT FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TR_IDLE  | not capturing; waits for arm (encoding 11 also lands here)
// TR_ARMED | waiting for a SYNC fetch matching the trigger
// TR_CAPT  | recording every RDY=1 cycle until stop
module bus_trace_fifo
    import bus_trace_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               phi2,
    input  logic               RES_L,
    input  logic [15:0]        extAB,
    input  logic [7:0]         extDB,
    input  logic               RW,
    input  logic               SYNC,
    input  logic               RDY,
    input  logic               arm,
    input  logic               trig_any,
    input  logic [15:0]        trig_addr,
    input  logic               stop,
    input  logic               clear,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [1:0]         state_o
);

    localparam int PTR_W = CNT_W - 1;

    tr_state_e          state_q, state_d;
    logic [15:0]        stamp_q, stamp_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;

    logic               trig_hit;
    logic               cap_cycle;
    logic               cap_en;
    logic               empty_w;
    logic               full_w;
    logic               rd_do;
    logic               wr_do;
    logic [PTR_W-1:0]   head_ptr;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] mem_rdata;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign trig_hit = RDY && SYNC && (trig_any || (extAB == trig_addr));

    always_comb begin
        state_d   = state_q;
        cap_cycle = 1'b0;
        case (state_q)
            TR_ARMED: begin
                if (stop) begin
                    state_d = TR_IDLE;
                end else if (arm) begin
                    state_d = TR_ARMED;
                end else if (trig_hit && !clear) begin
                    state_d   = TR_CAPT;
                    cap_cycle = 1'b1;
                end
            end
            TR_CAPT: begin
                if (stop) begin
                    state_d = TR_IDLE;
                end else if (RDY) begin
                    cap_cycle = 1'b1;
                end
            end
            default: begin
                if (!stop && arm) begin
                    state_d = TR_ARMED;
                end else begin
                    state_d = TR_IDLE;
                end
            end
        endcase
    end

    assign cap_en = cap_cycle && !clear;
    assign rd_do  = rd_en && !empty_w && !clear;
    // A full FIFO still accepts a write when the same edge pops the head.
    assign wr_do  = cap_en && (!full_w || rd_do);
    assign wdata  = tr_pack(stamp_q, extAB, extDB, RW, SYNC);

    always_comb begin
        stamp_d    = stamp_q + 16'd1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (cap_en && full_w && !rd_do);
        if (wr_do) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_do) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_do && !rd_do) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_do && rd_do) begin
            count_d = count_q - CNT_W'(1);
        end
        if (clear) begin
            stamp_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // Registered head: the next head is either the entry being written now
    // (when nothing else remains) or the stored entry at the next read slot.
    assign head_ptr = rd_do ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (count_d != '0) begin
            if (wr_do && (wr_ptr_q == head_ptr)) begin
                rd_data_d = wdata;
            end else begin
                rd_data_d = mem_rdata;
            end
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk_i  (phi2),
        .we_i   (wr_do),
        .waddr_i(wr_ptr_q),
        .wdata_i(wdata),
        .raddr_i(head_ptr),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge phi2 or negedge RES_L) begin
        if (!RES_L) begin
            state_q    <= TR_IDLE;
            stamp_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            stamp_q    <= stamp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_bus_trace_fifo.sv
// Scoreboard bench for bus_trace_fifo: stimulus pushes expected entries, a
// monitor pops and compares them whenever the bench pops a non-empty FIFO.
module tb_bus_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_RD   = 4'b0001;
    localparam logic [3:0] C_ARM  = 4'b0010;
    localparam logic [3:0] C_STOP = 4'b0100;
    localparam logic [3:0] C_CLR  = 4'b1000;

    logic             phi2;
    logic             RES_L;
    logic [15:0]      extAB;
    logic [7:0]       extDB;
    logic             RW;
    logic             SYNC;
    logic             RDY;
    logic             arm;
    logic             trig_any;
    logic [15:0]      trig_addr;
    logic             stop;
    logic             clear;
    logic             rd_en;
    logic [41:0]      rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [1:0]       state_o;

    int          checks = 0;
    int          errors = 0;
    logic [41:0] q[$];
    logic [15:0] exp_stamp;

    bus_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .phi2     (phi2),
        .RES_L    (RES_L),
        .extAB    (extAB),
        .extDB    (extDB),
        .RW       (RW),
        .SYNC     (SYNC),
        .RDY      (RDY),
        .arm      (arm),
        .trig_any (trig_any),
        .trig_addr(trig_addr),
        .stop     (stop),
        .clear    (clear),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .state_o  (state_o)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the entry pushed here
    // uses the stamp the DUT holds before the coming edge.
    task automatic step(input logic [15:0] ab, input logic [7:0] db, input logic rw,
                        input logic sy, input logic rdy, input logic [3:0] ctl, input bit push);
        extAB = ab; extDB = db; RW = rw; SYNC = sy; RDY = rdy;
        {clear, stop, arm, rd_en} = ctl;
        if (push) q.push_back({exp_stamp, ab, db, rw, sy});
        @(posedge phi2);
        #1;
        exp_stamp = ctl[3] ? 16'd0 : exp_stamp + 16'd1;
        {clear, stop, arm, rd_en} = C_NONE;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},    64'(state_o),  64'd0);
        chk({tag, "_count"},    64'(count),    64'd0);
        chk({tag, "_empty"},    64'(empty),    64'd1);
        chk({tag, "_full"},     64'(full),     64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_rd_data"},  64'(rd_data),  64'd0);
    endtask

    // Monitor: every pop of a non-empty FIFO must present the oldest expected entry.
    always @(negedge phi2) begin
        if (RES_L && rd_en && !empty) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry at %0t", rd_data, $time);
            end else begin
                chk("pop_entry", 64'(rd_data), 64'(q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RES_L = 1'b0; extAB = '0; extDB = '0; RW = 1'b1; SYNC = 1'b0; RDY = 1'b1;
        arm = 1'b0; trig_any = 1'b0; trig_addr = 16'hF000; stop = 1'b0; clear = 1'b0;
        rd_en = 1'b0; exp_stamp = 16'd0;
        #12;
        chk_reset("reset");
        RES_L = 1'b1;

        // Arm, wrong-address fetch, then matching fetch.
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_ARM, 0);
        chk("armed_state", 64'(state_o), 64'd1);
        step(16'hF002, 8'hA9, 1'b1, 1'b1, 1'b1, C_NONE, 0);
        chk("miss_state", 64'(state_o), 64'd1);
        chk("miss_count", 64'(count), 64'd0);
        step(16'hF000, 8'hA9, 1'b1, 1'b1, 1'b1, C_NONE, 1);
        chk("trig_state", 64'(state_o), 64'd2);
        chk("trig_count", 64'(count), 64'd1);
        chk("trig_empty", 64'(empty), 64'd0);
        chk("trig_entry", 64'(rd_data), 64'({16'h0002, 16'hF000, 8'hA9, 1'b1, 1'b1}));

        // 19 more capture cycles: entries 2..16 stored, 17..20 dropped.
        for (int i = 1; i < 20; i++) begin
            step(16'h0200 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b1, C_NONE, i <= 15);
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_overflow", 64'(overflow), 64'd1);
        chk("fill_state", 64'(state_o), 64'd2);

        // Full with simultaneous pop and capture.
        step(16'h0300, 8'hEE, 1'b0, 1'b0, 1'b1, C_RD, 1);
        chk("rw_full_count", 64'(count), 64'd16);
        chk("rw_full_full", 64'(full), 64'd1);

        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_STOP, 0);
        chk("stop_state", 64'(state_o), 64'd0);
        chk("stop_count", 64'(count), 64'd16);

        for (int i = 0; i < 16; i++) begin
            step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_RD, 0);
        end
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_queue", 64'(q.size()), 64'd0);
        chk("drain_hold", 64'(rd_data), 64'({16'd22, 16'h0300, 8'hEE, 1'b0, 1'b0}));

        // Pop on empty is a no-op.
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_RD, 0);
        chk("empty_rd_count", 64'(count), 64'd0);
        chk("empty_rd_hold", 64'(rd_data), 64'({16'd22, 16'h0300, 8'hEE, 1'b0, 1'b0}));

        // RDY stall: three stalled cycles, next entry stamp jumps by 4.
        trig_any = 1'b1;
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_ARM, 0);
        step(16'h1234, 8'h55, 1'b1, 1'b1, 1'b1, C_NONE, 1);
        for (int i = 0; i < 3; i++) begin
            step(16'h1235, 8'h00, 1'b1, 1'b0, 1'b0, C_NONE, 0);
        end
        chk("stall_count", 64'(count), 64'd1);
        step(16'h1235, 8'h66, 1'b0, 1'b0, 1'b1, C_NONE, 1);
        chk("post_stall_count", 64'(count), 64'd2);
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_STOP, 0);
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_RD, 0);
        chk("stall_first", 64'(rd_data), 64'({16'd46, 16'h1235, 8'h66, 1'b0, 1'b0}));
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_RD, 0);
        chk("stall_drain", 64'(count), 64'd0);
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // clear + stop together during capture.
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_ARM, 0);
        step(16'h4000, 8'h11, 1'b1, 1'b1, 1'b1, C_NONE, 1);
        step(16'h4001, 8'h22, 1'b1, 1'b0, 1'b1, C_NONE, 1);
        chk("pre_clear_count", 64'(count), 64'd2);
        step(16'h4002, 8'h33, 1'b1, 1'b0, 1'b1, C_CLR | C_STOP, 0);
        q.delete();
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_overflow", 64'(overflow), 64'd0);
        chk("clear_state", 64'(state_o), 64'd0);
        chk("clear_empty", 64'(empty), 64'd1);

        // Stamp restarts from 0 on the clear edge.
        step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, C_ARM, 0);
        step(16'h5000, 8'h33, 1'b1, 1'b1, 1'b1, C_NONE, 1);
        chk("clear_stamp_entry", 64'(rd_data), 64'({16'h0001, 16'h5000, 8'h33, 1'b1, 1'b1}));
        step(16'h5001, 8'h44, 1'b1, 1'b0, 1'b1, C_NONE, 1);
        chk("pre_reset_count", 64'(count), 64'd2);

        // Asynchronous reset mid-capture.
        #3;
        RES_L = 1'b0;
        #1;
        q.delete();
        chk_reset("midreset");
        #10;
        RES_L = 1'b1;
        #10;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
